// File: rtl/sync_fifo_pkg.sv
// +--------------------------------------------------------------------+
// | sync_fifo_pkg : shared defaults and width helpers for sync_fifo     |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

package sync_fifo_pkg;

   localparam int FIFO_WIDTH_DEF = 32;
   localparam int FIFO_DEPTH_DEF = 8;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so the count can hold the value DEPTH itself.
   function automatic int count_width(input int depth);
      return ptr_width(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// +--------------------------------------------------------------------+
// | sync_fifo_mem : DEPTH x WIDTH register array, sync write/async read |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int AW    = ptr_width(FIFO_DEPTH_DEF)
)(
   input  logic             Clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage is deliberately left out of reset.
   always_ff @(posedge Clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// +--------------------------------------------------------------------+
// | sync_fifo_param : parametrised single-clock FIFO with count/flags.  |
// | Macro SYNC_FIFO_FWFT_EN selects first-word fall-through output.     |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH    = FIFO_WIDTH_DEF,
   parameter int DEPTH    = FIFO_DEPTH_DEF,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2
)(
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   en,
   input  logic                   wr,
   input  logic [WIDTH-1:0]       din,
   input  logic                   rd,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic                   almost_empty,
   output logic                   almost_full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);

   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             do_wr, do_rd;
   logic             mem_we;
   logic [WIDTH-1:0] rd_data;

   assign empty        = (count_q == '0);
   assign full         = (count_q == FULL_LVL);
   assign almost_empty = (count_q <= AE_LVL);
   assign almost_full  = (count_q >= AF_LVL);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      do_wr       = 1'b0;
      do_rd       = 1'b0;
      if (en) begin
         // A full FIFO still accepts a write when the same cycle frees a slot.
         do_wr       = wr & (~full | rd);
         do_rd       = rd & ~empty;
         overflow_d  = wr & full & ~rd;
         underflow_d = rd & empty;
         if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign mem_we = do_wr & ~Rst;

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .Clk   (Clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is visible straight from the array; zero while empty.
   assign dout = empty ? '0 : rd_data;
`else
   logic [WIDTH-1:0] dout_q, dout_d;

   always_comb begin
      dout_d = dout_q;
      if (do_rd) dout_d = rd_data;
   end

   always_ff @(posedge Clk) begin
      if (Rst) dout_q <= '0;
      else     dout_q <= dout_d;
   end

   assign dout = dout_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// +--------------------------------------------------------------------+
// | tb_sync_fifo_param : scoreboard bench for sync_fifo_param           |
// | Revision           : 1.0                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sync_fifo_param;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        en = 1'b0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        empty, full, almost_empty, almost_full;
   logic [3:0]  count;
   logic        overflow, underflow;

   always #5 Clk = ~Clk;

   sync_fifo_param #(
      .WIDTH    (32),
      .DEPTH    (8),
      .AF_LEVEL (6),
      .AE_LEVEL (2)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .en           (en),
      .wr           (wr),
      .din          (din),
      .rd           (rd),
      .dout         (dout),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   typedef struct {
      int          due;
      logic [31:0] dout;
      logic [3:0]  cnt;
      logic        emp, ful, ae, af, ov, un;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mq[$];
   logic [31:0] m_dout = '0;
   logic        m_ov = 1'b0;
   logic        m_un = 1'b0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: compares the DUT state after each edge with the queued expectation.
   always @(posedge Clk) begin
      #2;
      while (sb.size() > 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         check("dout",         dout,               e.dout);
         check("count",        {28'd0, count},     {28'd0, e.cnt});
         check("empty",        {31'd0, empty},     {31'd0, e.emp});
         check("full",         {31'd0, full},      {31'd0, e.ful});
         check("almost_empty", {31'd0, almost_empty}, {31'd0, e.ae});
         check("almost_full",  {31'd0, almost_full},  {31'd0, e.af});
         check("overflow",     {31'd0, overflow},  {31'd0, e.ov});
         check("underflow",    {31'd0, underflow}, {31'd0, e.un});
      end
   end

   task automatic step(input logic r, input logic e, input logic w,
                       input logic [31:0] d, input logic rq);
      logic fm, em, dw, dr;
      exp_t x;
      @(posedge Clk);
      #1;
      Rst = r; en = e; wr = w; din = d; rd = rq;
      if (r) begin
         mq.delete();
         m_dout = '0; m_ov = 1'b0; m_un = 1'b0;
      end else if (e) begin
         fm   = (mq.size() == 8);
         em   = (mq.size() == 0);
         m_ov = w && fm && !rq;
         m_un = rq && em;
         dr   = rq && !em;
         dw   = w && (!fm || rq);
         if (dr) m_dout = mq.pop_front();
         if (dw) mq.push_back(d);
      end else begin
         m_ov = 1'b0; m_un = 1'b0;
      end
      x.due  = cyc + 1;
`ifdef SYNC_FIFO_FWFT_EN
      x.dout = (mq.size() == 0) ? 32'd0 : mq[0];
`else
      x.dout = m_dout;
`endif
      x.cnt  = 4'(mq.size());
      x.emp  = (mq.size() == 0);
      x.ful  = (mq.size() == 8);
      x.ae   = (mq.size() <= 2);
      x.af   = (mq.size() >= 6);
      x.ov   = m_ov;
      x.un   = m_un;
      sb.push_back(x);
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
   endtask

   // Holds idle inputs for one more edge and lands just after it.
   task automatic settle();
      @(posedge Clk);
      #2;
   endtask

   initial begin
      // Reset then idle
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b1);
      idle();
      settle();
      check("hand_reset_count", {28'd0, count}, 32'd0);
      check("hand_reset_dout",  dout, 32'd0);

      // Fill 1..8, then a rejected 9th write
      for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b1, 32'(i), 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h99, 1'b0);
      idle();
      settle();
      check("hand_fill_full",  {31'd0, full}, 32'd1);
      check("hand_fill_count", {28'd0, count}, 32'd8);

      // Drain, then an extra read
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      idle();
      settle();
`ifdef SYNC_FIFO_FWFT_EN
      check("hand_drain_dout", dout, 32'd0);
`else
      check("hand_drain_dout", dout, 32'd8);
`endif

      // Simultaneous wr&rd when full, then when empty
      for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b1, 32'(i), 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'hA5, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h3C, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);

      // Interleaved pairs across pointer wrap
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 1'b1, 1'b1, 32'h100 + 32'(k), 1'b0);
         if (k % 3 == 0) step(1'b0, 1'b1, 1'b1, 32'h200 + 32'(k), 1'b1);
         step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      end

      // Enable low freezes everything
      step(1'b0, 1'b1, 1'b1, 32'h11, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h22, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hEE, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);

      // Reset mid-operation discards data
      step(1'b1, 1'b1, 1'b1, 32'h33, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h77, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      idle();
      settle();
`ifdef SYNC_FIFO_FWFT_EN
      check("hand_post_reset_dout", dout, 32'd0);
`else
      check("hand_post_reset_dout", dout, 32'h77);
`endif

      repeat (3) @(posedge Clk);
      #3;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; next-generation data buffer for 32-bit streaming paths, generalised in width and depth.
Adds correct occupancy tracking, simultaneous read/write, almost-full/almost-empty thresholds and overflow/underflow pulses.
Sits between producer and consumer blocks in the same clock domain.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous, active-high reset
en  in  1  global enable; 0 freezes pointers, count and dout
wr  in  1  write request
din  in  WIDTH  write data
rd  in  1  read request
dout  out  WIDTH  read data
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: wr rejected because full
underflow  out  1  one-cycle pulse: rd rejected because empty

Behaviour:
- Rst has priority over en. Next cycle: wr_ptr=rd_ptr=0, count=0, dout=0, overflow=underflow=0; empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0). Storage contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate count register, not derived from pointer difference.
- Flags are combinational decodes of the count register, so they reflect state after the last edge.
- Qualified operations, evaluated only when en=1 and Rst=0:
  - do_wr = wr & (~full | rd)
  - do_rd = rd & ~empty
- Write: mem[wr_ptr] <= din; wr_ptr +1.
- Read (default mode): dout <= mem[rd_ptr]; rd_ptr +1; latency 1 cycle from rd to dout valid. dout holds its value when no read occurs.
- Count update:
  - do_wr only: +1
  - do_rd only: -1
  - both: unchanged
- Full with wr&rd: both accepted; oldest word read, new word written to the freed slot; count stays DEPTH.
- Empty with wr&rd: write accepted, read rejected; underflow pulses; count becomes 1.
- overflow <= en & wr & full & ~rd
- underflow <= en & rd & empty
- Both pulse registers are cleared to 0 on any cycle where the pulse condition is false.
- en=0: no state change except overflow/underflow clear to 0; requests are ignored without error pulses.
- Reset mid-operation discards all queued data; the first write after reset lands at mem[0].

Optional Feature:
Macro SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined: dout presents mem[rd_ptr] combinationally whenever ~empty, so the head word is visible with zero latency. rd pops the head; dout shows the next word after the edge. While empty, dout = 0. Full-with-wr&rd behaviour is unchanged.
- Undefined: registered 1-cycle read as above.

Decomposition:
- Package sync_fifo_pkg: function clog2-based pointer/count width helpers; localparam defaults FIFO_WIDTH_DEF=32, FIFO_DEPTH_DEF=8.
- One sub-module, sync_fifo_mem: DEPTH x WIDTH register array with a synchronous write port and an asynchronous read address.
- Top level holds pointers, count, flags and the dout register.

Test Plan:
- Reset then idle: Rst=1 for 2 cycles -> count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0.
- Fill: DEPTH=8, write 0x1..0x8 on consecutive cycles -> count steps 1..8; almost_full first at count=6; full=1 after 8th write; 9th wr alone -> overflow pulses 1 cycle, count stays 8.
- Drain: then rd for 8 cycles -> dout=0x1..0x8 in order, 1 cycle after each rd; empty=1 after last read; extra rd -> underflow pulse, dout holds 0x8.
- Simultaneous: with count=8, wr=1 din=0xA5 rd=1 -> dout=0x1, count=8, no overflow; at count=0, wr&rd -> count=1, underflow=1.
- Wrap and enable: 20 interleaved write/read pairs -> data order preserved across pointer wrap; with en=0, wr/rd asserted -> no change in count or dout, no error pulses.
- FWFT build: write 0x55 into empty FIFO -> dout=0x55 on the next cycle with no rd; rd -> dout=0 and empty=1.
